// File: rtl/sim_uart_pkg.sv
// Shared constants and helpers for the multi-channel simulation UART console mux.
package sim_uart_pkg;

    localparam logic [7:0] NEWLINE = 8'h0A;
    localparam int unsigned CYCLE_W = 64;
    localparam int unsigned DROP_W  = 32;

    // Channel-index width; a single channel still needs one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sim_uart_fifo.sv
// Single-channel synchronous FIFO; a push is accepted while full if a pop happens in the same cycle.
module sim_uart_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // When full, wr_ptr equals rd_ptr: the pop reads the old word before this edge overwrites it.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/sim_uart_mux.sv
// Captures per-channel UART bytes into FIFOs and drains them round-robin onto one tagged host stream.
module sim_uart_mux
    import sim_uart_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned CH_W  = ch_width(NUM_CH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        io_uart_out_valid,
    input  logic [NUM_CH*DATA_W-1:0] io_uart_out_ch,
    input  logic [CYCLE_W-1:0]       io_logCtrl_log_begin,
    input  logic [CYCLE_W-1:0]       io_logCtrl_log_end,
    output logic                     host_valid,
    input  logic                     host_ready,
    output logic [DATA_W-1:0]        host_ch,
    output logic [CH_W-1:0]          host_chan,
    output logic                     host_flush,
    output logic [NUM_CH-1:0]        overflow,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic [CYCLE_W-1:0]       cycle_cnt
);

    logic [NUM_CH-1:0] fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
    logic [DATA_W-1:0] fifo_rdata [NUM_CH];
    logic [CNT_W-1:0]  fifo_count [NUM_CH];

    logic              host_valid_q, host_valid_d;
    logic [DATA_W-1:0] host_ch_q, host_ch_d;
    logic [CH_W-1:0]   host_chan_q, host_chan_d;
    logic              host_flush_q, host_flush_d;
    logic [NUM_CH-1:0] overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CYCLE_W-1:0] cycle_q, cycle_d;
    logic [CH_W-1:0]   rr_q, rr_d;

    logic              in_win, load, any_avail;
    logic [CH_W-1:0]   win, cand;
    logic [DROP_W:0]   drop_sum;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            sim_uart_fifo #(
                .DEPTH  (DEPTH),
                .DATA_W (DATA_W)
            ) u_fifo (
                .clock   (clock),
                .reset   (reset),
                .push    (fifo_push[g]),
                .pop     (fifo_pop[g]),
                .wr_data (io_uart_out_ch[g*DATA_W +: DATA_W]),
                .rd_data (fifo_rdata[g]),
                .full    (fifo_full[g]),
                .empty   (fifo_empty[g]),
                .count   (fifo_count[g])
            );

            always_ff @(posedge clock) begin
                if (!reset) assert (fifo_full[g] == (32'(fifo_count[g]) == DEPTH));
            end
        end
    endgenerate

    assign in_win = (io_logCtrl_log_end == '0) ||
                    ((cycle_q >= io_logCtrl_log_begin) && (cycle_q < io_logCtrl_log_end));

    // First non-empty channel scanning from rr upward, modulo NUM_CH.
    always_comb begin
        any_avail = 1'b0;
        win       = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            cand = CH_W'((32'(rr_q) + k) % NUM_CH);
            if (!any_avail && !fifo_empty[cand]) begin
                any_avail = 1'b1;
                win       = cand;
            end
        end
    end

    always_comb begin
        load         = ~host_valid_q | host_ready;
        host_valid_d = host_valid_q;
        host_ch_d    = host_ch_q;
        host_chan_d  = host_chan_q;
        host_flush_d = host_flush_q;
        rr_d         = rr_q;
        fifo_pop     = '0;
        fifo_push    = '0;
        drop         = '0;

        if (load) begin
            host_valid_d = any_avail;
            if (any_avail) begin
                host_ch_d    = fifo_rdata[win];
                host_chan_d  = win;
                host_flush_d = (fifo_rdata[win] == DATA_W'(NEWLINE));
                rr_d         = CH_W'((32'(win) + 1) % NUM_CH);
            end
        end

        for (int unsigned i = 0; i < NUM_CH; i++) begin
            fifo_pop[i]  = load && any_avail && (win == CH_W'(i));
            fifo_push[i] = io_uart_out_valid[i] & in_win & (~fifo_full[i] | fifo_pop[i]);
            drop[i]      = io_uart_out_valid[i] & in_win & fifo_full[i] & ~fifo_pop[i];
        end

        drop_sum = {1'b0, drop_cnt_q};
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            drop_sum = drop_sum + (DROP_W + 1)'(drop[i]);
        end
        drop_cnt_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        overflow_d = overflow_q | drop;
        cycle_d    = cycle_q + CYCLE_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            host_valid_q <= 1'b0;
            host_ch_q    <= '0;
            host_chan_q  <= '0;
            host_flush_q <= 1'b0;
            overflow_q   <= '0;
            drop_cnt_q   <= '0;
            cycle_q      <= '0;
            rr_q         <= '0;
        end else begin
            host_valid_q <= host_valid_d;
            host_ch_q    <= host_ch_d;
            host_chan_q  <= host_chan_d;
            host_flush_q <= host_flush_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
            cycle_q      <= cycle_d;
            rr_q         <= rr_d;
        end
    end

    assign host_valid = host_valid_q;
    assign host_ch    = host_ch_q;
    assign host_chan  = host_chan_q;
    assign host_flush = host_flush_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;
    assign cycle_cnt  = cycle_q;

endmodule
